// File: rtl/tl_source_compactor_pkg.sv
// TL-UH channel types, opcodes and beat helpers shared by the source compactor slice.
// The struct widths are fixed here; the top-level parameters are expected to match them.
package tl_source_compactor_pkg;

    localparam int TL_DW         = 64;
    localparam int TL_AW         = 56;
    localparam int TL_HSW        = 8;
    localparam int TL_DSW        = 2;
    localparam int TL_SIZE_WIDTH = 3;
    localparam int TL_MW         = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        tl_a_op_e                 opcode;
        logic [2:0]               param;
        logic [TL_SIZE_WIDTH-1:0] size;
        logic [TL_HSW-1:0]        source;
        logic [TL_AW-1:0]         address;
        logic [TL_MW-1:0]         mask;
        logic                     corrupt;
        logic [TL_DW-1:0]         data;
    } tl_a_host_t;

    typedef struct packed {
        tl_a_op_e                 opcode;
        logic [2:0]               param;
        logic [TL_SIZE_WIDTH-1:0] size;
        logic [TL_DSW-1:0]        source;
        logic [TL_AW-1:0]         address;
        logic [TL_MW-1:0]         mask;
        logic                     corrupt;
        logic [TL_DW-1:0]         data;
    } tl_a_dev_t;

    typedef struct packed {
        tl_d_op_e                 opcode;
        logic [1:0]               param;
        logic [TL_SIZE_WIDTH-1:0] size;
        logic [TL_HSW-1:0]        source;
        logic                     sink;
        logic                     denied;
        logic                     corrupt;
        logic [TL_DW-1:0]         data;
    } tl_d_host_t;

    typedef struct packed {
        tl_d_op_e                 opcode;
        logic [1:0]               param;
        logic [TL_SIZE_WIDTH-1:0] size;
        logic [TL_DSW-1:0]        source;
        logic                     sink;
        logic                     denied;
        logic                     corrupt;
        logic [TL_DW-1:0]         data;
    } tl_d_dev_t;

    // Transfers wider than one bus word are split into 2**(size - log2(bytes per beat)) beats.
    function automatic int unsigned tl_beats(logic [TL_SIZE_WIDTH-1:0] size,
                                             int unsigned data_width);
        int unsigned lg;
        int unsigned sz;
        int unsigned beats;
        lg    = $clog2(data_width / 8);
        sz    = 32'(size);
        beats = 32'd1;
        if (sz > lg) begin
            beats = 32'd1 << (sz - lg);
        end
        return beats;
    endfunction

    function automatic logic tl_has_data_a(tl_a_op_e op);
        return (op == PutFullData) || (op == PutPartialData);
    endfunction

    function automatic logic tl_has_data_d(tl_d_op_e op);
        return op == AccessAckData;
    endfunction

endpackage

// File: rtl/tl_source_compactor_alloc.sv
// Device slot allocator: free bitmap, lowest-free picker and slot-to-host-source table.
module tl_source_compactor_alloc #(
    parameter int HostSourceWidth   = 8,
    parameter int DeviceSourceWidth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         alloc_en,
    input  logic [HostSourceWidth-1:0]   alloc_source,
    output logic [DeviceSourceWidth-1:0] alloc_slot,
    output logic                         alloc_avail,
    input  logic                         free_en,
    input  logic [DeviceSourceWidth-1:0] free_slot,
    input  logic [DeviceSourceWidth-1:0] lookup_slot,
    output logic [HostSourceWidth-1:0]   lookup_source,
    output logic                         lookup_slot_free
);

    localparam int NumSlots = 2 ** DeviceSourceWidth;

    logic [NumSlots-1:0]        free_q;
    logic [NumSlots-1:0]        free_d;
    logic [HostSourceWidth-1:0] src_table_q [NumSlots];

    // Scanning downwards lets the lowest free index win.
    always_comb begin
        alloc_slot = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_slot = DeviceSourceWidth'(i);
            end
        end
    end

    assign alloc_avail      = |free_q;
    assign lookup_source    = src_table_q[lookup_slot];
    assign lookup_slot_free = free_q[lookup_slot];

    // Allocation only ever picks a slot that is free in free_q, so it cannot collide with a free.
    always_comb begin
        free_d = free_q;
        if (alloc_en) begin
            free_d[alloc_slot] = 1'b0;
        end
        if (free_en) begin
            free_d[free_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_q <= '1;
            for (int i = 0; i < NumSlots; i++) begin
                src_table_q[i] <= '0;
            end
        end else begin
            free_q <= free_d;
            if (alloc_en) begin
                src_table_q[alloc_slot] <= alloc_source;
            end
        end
    end

endmodule

// File: rtl/tl_source_compactor.sv
// TL-UH source-ID compactor: maps wide host sources onto a dense device slot space
// with zero-latency pass-through of both A and D channels.
module tl_source_compactor
    import tl_source_compactor_pkg::*;
#(
    parameter int DataWidth         = TL_DW,
    parameter int AddrWidth         = TL_AW,
    parameter int HostSourceWidth   = TL_HSW,
    parameter int DeviceSourceWidth = TL_DSW,
    parameter int MaxSize           = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,

    input  logic       host_a_valid,
    output logic       host_a_ready,
    input  tl_a_host_t host_a,
    output logic       host_d_valid,
    input  logic       host_d_ready,
    output tl_d_host_t host_d,

    output logic       device_a_valid,
    input  logic       device_a_ready,
    output tl_a_dev_t  device_a,
    input  logic       device_d_valid,
    output logic       device_d_ready,
    input  tl_d_dev_t  device_d,

    output logic       host_b_valid,
    output logic       host_c_ready,
    output logic       host_e_ready,
    output logic       device_b_ready,
    output logic       device_c_valid,
    output logic       device_e_valid
);

    localparam int BeatWidth = MaxSize + 1;

    logic                         lock_q;
    logic [DeviceSourceWidth-1:0] lock_slot_q;
    logic [BeatWidth-1:0]         a_beat_q;
    logic [BeatWidth-1:0]         d_beat_q;
    logic [BeatWidth-1:0]         a_beats;
    logic [BeatWidth-1:0]         d_beats;
    logic                         a_last;
    logic                         d_last;
    logic                         a_fire;
    logic                         d_fire;
    logic                         slot_ok;
    logic                         alloc_avail;
    logic                         lookup_slot_free;
    logic [DeviceSourceWidth-1:0] alloc_slot;
    logic [DeviceSourceWidth-1:0] a_slot;
    logic [HostSourceWidth-1:0]   lookup_source;

    assign a_beats = tl_has_data_a(host_a.opcode)
                     ? BeatWidth'(tl_beats(host_a.size, DataWidth)) : BeatWidth'(1);
    assign d_beats = tl_has_data_d(device_d.opcode)
                     ? BeatWidth'(tl_beats(device_d.size, DataWidth)) : BeatWidth'(1);
    assign a_last  = (a_beat_q == a_beats - BeatWidth'(1));
    assign d_last  = (d_beat_q == d_beats - BeatWidth'(1));

    // A locked burst keeps its slot and never waits for a free one.
    assign slot_ok = lock_q | alloc_avail;
    assign a_slot  = lock_q ? lock_slot_q : alloc_slot;

    always_comb begin
        device_a_valid = 1'b0;
        host_a_ready   = 1'b0;
        host_d_valid   = 1'b0;
        device_d_ready = 1'b0;
        if (!rst_i) begin
            device_a_valid = host_a_valid & slot_ok;
            host_a_ready   = device_a_ready & slot_ok;
            host_d_valid   = device_d_valid;
            device_d_ready = host_d_ready;
        end
    end

    assign a_fire = host_a_valid & host_a_ready;
    assign d_fire = device_d_valid & device_d_ready;

    always_comb begin
        device_a.opcode  = host_a.opcode;
        device_a.param   = host_a.param;
        device_a.size    = host_a.size;
        device_a.source  = a_slot;
        device_a.address = host_a.address;
        device_a.mask    = host_a.mask;
        device_a.corrupt = host_a.corrupt;
        device_a.data    = host_a.data;

        host_d.opcode    = device_d.opcode;
        host_d.param     = device_d.param;
        host_d.size      = device_d.size;
        host_d.source    = lookup_source;
        host_d.sink      = device_d.sink;
        host_d.denied    = device_d.denied;
        host_d.corrupt   = device_d.corrupt;
        host_d.data      = device_d.data;
    end

    assign host_b_valid   = 1'b0;
    assign host_c_ready   = 1'b1;
    assign host_e_ready   = 1'b1;
    assign device_b_ready = 1'b1;
    assign device_c_valid = 1'b0;
    assign device_e_valid = 1'b0;

    tl_source_compactor_alloc #(
        .HostSourceWidth   (HostSourceWidth),
        .DeviceSourceWidth (DeviceSourceWidth)
    ) u_alloc (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .alloc_en         (a_fire & ~lock_q),
        .alloc_source     (host_a.source),
        .alloc_slot       (alloc_slot),
        .alloc_avail      (alloc_avail),
        .free_en          (d_fire & d_last),
        .free_slot        (device_d.source),
        .lookup_slot      (device_d.source),
        .lookup_source    (lookup_source),
        .lookup_slot_free (lookup_slot_free)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q      <= 1'b0;
            lock_slot_q <= '0;
            a_beat_q    <= '0;
            d_beat_q    <= '0;
        end else begin
            assert (DataWidth == TL_DW && AddrWidth == TL_AW &&
                    HostSourceWidth == TL_HSW && DeviceSourceWidth == TL_DSW);
            assert (!(device_d_valid && lookup_slot_free));
            assert (!(host_a_valid && int'(host_a.size) > MaxSize));

            if (a_fire) begin
                if (a_last) begin
                    a_beat_q <= '0;
                    lock_q   <= 1'b0;
                end else begin
                    a_beat_q <= a_beat_q + BeatWidth'(1);
                    if (!lock_q) begin
                        lock_q      <= 1'b1;
                        lock_slot_q <= alloc_slot;
                    end
                end
            end

            if (d_fire) begin
                d_beat_q <= d_last ? '0 : d_beat_q + BeatWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_tl_source_compactor.sv
// Randomized and directed bench for tl_source_compactor against a slot-occupancy model.
module tb_tl_source_compactor;
    import tl_source_compactor_pkg::*;

    localparam int NumSlots = 4;
    localparam int BytesLog = $clog2(TL_DW / 8);

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       host_a_valid = 1'b0;
    logic       host_a_ready;
    tl_a_host_t host_a;
    logic       host_d_valid;
    logic       host_d_ready = 1'b1;
    tl_d_host_t host_d;
    logic       device_a_valid;
    logic       device_a_ready = 1'b1;
    tl_a_dev_t  device_a;
    logic       device_d_valid = 1'b0;
    logic       device_d_ready;
    tl_d_dev_t  device_d;
    logic       host_b_valid, host_c_ready, host_e_ready;
    logic       device_b_ready, device_c_valid, device_e_valid;

    always #5 clk_i = ~clk_i;

    tl_source_compactor dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .host_a_valid   (host_a_valid),
        .host_a_ready   (host_a_ready),
        .host_a         (host_a),
        .host_d_valid   (host_d_valid),
        .host_d_ready   (host_d_ready),
        .host_d         (host_d),
        .device_a_valid (device_a_valid),
        .device_a_ready (device_a_ready),
        .device_a       (device_a),
        .device_d_valid (device_d_valid),
        .device_d_ready (device_d_ready),
        .device_d       (device_d),
        .host_b_valid   (host_b_valid),
        .host_c_ready   (host_c_ready),
        .host_e_ready   (host_e_ready),
        .device_b_ready (device_b_ready),
        .device_c_valid (device_c_valid),
        .device_e_valid (device_e_valid)
    );

    // Reference model: which slots hold a live request, whose it is and what reply it expects.
    bit  busy      [NumSlots];
    int  owner     [NumSlots];
    bit  slotIsGet [NumSlots];
    int  slotSize  [NumSlots];
    int  aLeft, aSlot, dLeft;
    int  nChecks = 0;
    int  nPass   = 0;
    bit  fa, fd;
    tl_a_host_t idleA;
    tl_d_dev_t  idleD;

    function automatic int beatsOf(int size);
        return (size > BytesLog) ? (1 << (size - BytesLog)) : 1;
    endfunction

    function automatic tl_a_host_t mkA(tl_a_op_e op, int size, int src);
        tl_a_host_t a;
        a.opcode  = op;
        a.param   = '0;
        a.size    = TL_SIZE_WIDTH'(size);
        a.source  = TL_HSW'(src);
        a.address = TL_AW'({$urandom(), $urandom()});
        a.mask    = '1;
        a.corrupt = 1'b0;
        a.data    = {$urandom(), $urandom()};
        return a;
    endfunction

    function automatic tl_d_dev_t mkD(tl_d_op_e op, int size, int slot);
        tl_d_dev_t d;
        d.opcode  = op;
        d.param   = '0;
        d.size    = TL_SIZE_WIDTH'(size);
        d.source  = TL_DSW'(slot);
        d.sink    = 1'b0;
        d.denied  = 1'b0;
        d.corrupt = 1'b0;
        d.data    = {$urandom(), $urandom()};
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int s = 0; s < NumSlots; s++) busy[s] = 1'b0;
        aLeft = 0;
        dLeft = 0;
    endtask

    task automatic doReset(input int cycles);
        rst_i          = 1'b1;
        host_a_valid   = 1'b1;
        device_a_ready = 1'b1;
        device_d_valid = 1'b1;
        device_d       = idleD;
        host_d_ready   = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            #3;
            checkOutput("rst_dev_a_valid", 64'(device_a_valid), 64'(0));
            checkOutput("rst_host_a_ready", 64'(host_a_ready), 64'(0));
            checkOutput("rst_host_d_valid", 64'(host_d_valid), 64'(0));
            checkOutput("rst_dev_d_ready", 64'(device_d_ready), 64'(0));
            @(posedge clk_i);
            #1;
        end
        modelReset();
        rst_i          = 1'b0;
        host_a_valid   = 1'b0;
        device_d_valid = 1'b0;
    endtask

    // One cycle: drive, compare against the model mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input bit aval, input tl_a_host_t a, input bit dval,
                                 input tl_d_dev_t d, input bit hdr, input bit dar,
                                 output bit aFired, output bit dFired);
        int expSlot;
        bit expReady;
        host_a_valid   = aval;
        host_a         = a;
        device_d_valid = dval;
        device_d       = d;
        host_d_ready   = hdr;
        device_a_ready = dar;
        #3;
        expSlot = -1;
        if (aLeft > 0) expSlot = aSlot;
        else for (int i = NumSlots - 1; i >= 0; i--) if (!busy[i]) expSlot = i;
        expReady = (expSlot >= 0) && dar;
        checkOutput("dev_a_valid", 64'(device_a_valid), 64'(aval && expSlot >= 0));
        checkOutput("host_a_ready", 64'(host_a_ready), 64'(expReady));
        if (aval && expSlot >= 0) begin
            checkOutput("dev_a_source", 64'(device_a.source), 64'(expSlot));
            checkOutput("dev_a_address", 64'(device_a.address), 64'(a.address));
            checkOutput("dev_a_data", device_a.data, a.data);
        end
        checkOutput("host_d_valid", 64'(host_d_valid), 64'(dval));
        checkOutput("dev_d_ready", 64'(device_d_ready), 64'(hdr));
        if (dval) begin
            checkOutput("host_d_source", 64'(host_d.source), 64'(owner[d.source]));
            checkOutput("host_d_data", host_d.data, d.data);
        end
        aFired = aval && expReady;
        dFired = dval && hdr;
        @(posedge clk_i);
        if (aFired) begin
            if (aLeft == 0) begin
                busy[expSlot]      = 1'b1;
                owner[expSlot]     = int'(a.source);
                slotIsGet[expSlot] = (a.opcode == Get);
                slotSize[expSlot]  = int'(a.size);
                if (a.opcode != Get && beatsOf(int'(a.size)) > 1) begin
                    aLeft = beatsOf(int'(a.size)) - 1;
                    aSlot = expSlot;
                end
            end else begin
                aLeft--;
            end
        end
        if (dFired) begin
            if (dLeft == 0) dLeft = (d.opcode == AccessAckData) ? beatsOf(int'(d.size)) : 1;
            dLeft--;
            if (dLeft == 0) busy[d.source] = 1'b0;
        end
        #1;
    endtask

    task automatic sendA(input tl_a_host_t a);
        applyStimulus(1'b1, a, 1'b0, idleD, 1'b1, 1'b1, fa, fd);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, idleA, 1'b0, idleD, 1'b1, 1'b1, fa, fd);
    endtask

    task automatic respond(input int s);
        int       n;
        tl_d_op_e op;
        n  = slotIsGet[s] ? beatsOf(slotSize[s]) : 1;
        op = slotIsGet[s] ? AccessAckData : AccessAck;
        for (int b = 0; b < n; b++)
            applyStimulus(1'b0, idleA, 1'b1, mkD(op, slotSize[s], s), 1'b1, 1'b1, fa, fd);
    endtask

    task automatic drain();
        for (int s = 0; s < NumSlots; s++)
            if (busy[s] && !(aLeft > 0 && aSlot == s)) respond(s);
    endtask

    initial begin
        tl_a_host_t a, g;
        tl_d_dev_t  d, rd;
        tl_a_host_t ra;
        bit         aPend, dPend, noNew;
        int         pick;

        idleA  = mkA(Get, 0, 0);
        idleD  = mkD(AccessAck, 0, 0);
        host_a = idleA;
        device_d = idleD;
        doReset(2);
        checkOutput("tie_host_b_valid", 64'(host_b_valid), 64'(0));
        checkOutput("tie_host_c_ready", 64'(host_c_ready), 64'(1));
        checkOutput("tie_host_e_ready", 64'(host_e_ready), 64'(1));
        checkOutput("tie_dev_b_ready", 64'(device_b_ready), 64'(1));
        checkOutput("tie_dev_c_valid", 64'(device_c_valid), 64'(0));
        checkOutput("tie_dev_e_valid", 64'(device_e_valid), 64'(0));

        // Single Get, response, then slot 0 is reused immediately.
        sendA(mkA(Get, 3, 'h5A));
        respond(0);
        sendA(mkA(Get, 0, 'h11));
        drain();

        // Fill all slots, a fifth Get stalls until slot 2 frees.
        for (int i = 0; i < 4; i++) sendA(mkA(Get, 0, 'h10 + i));
        g = mkA(Get, 0, 'h20);
        sendA(g);
        applyStimulus(1'b1, g, 1'b1, mkD(AccessAckData, 0, 2), 1'b1, 1'b1, fa, fd);
        applyStimulus(1'b1, g, 1'b0, idleD, 1'b1, 1'b1, fa, fd);
        drain();

        // 8-beat Put on slot 2 while slot 0 frees mid-burst.
        sendA(mkA(Get, 0, 'h01));
        sendA(mkA(Get, 0, 'h02));
        for (int b = 0; b < 8; b++) begin
            a = mkA(PutFullData, 6, 'h7F);
            applyStimulus(1'b1, a, b == 2, mkD(AccessAckData, 0, 0), 1'b1, 1'b1, fa, fd);
        end
        drain();

        // 8-beat AccessAckData with a 5-cycle host stall and a Get slipped in.
        sendA(mkA(Get, 6, 'h33));
        for (int b = 0; b < 8; b++) begin
            d = mkD(AccessAckData, 6, 0);
            if (b == 4)
                for (int k = 0; k < 5; k++)
                    applyStimulus(k == 2, mkA(Get, 0, 'h34), 1'b1, d, 1'b0, 1'b1, fa, fd);
            applyStimulus(1'b0, idleA, 1'b1, d, 1'b1, 1'b1, fa, fd);
        end
        sendA(mkA(Get, 0, 'h35));
        drain();

        // Same-cycle free of slot 0 and new Get: no bypass.
        for (int i = 0; i < 4; i++) sendA(mkA(Get, 0, 'h60 + i));
        g = mkA(Get, 0, 'h66);
        applyStimulus(1'b1, g, 1'b1, mkD(AccessAckData, 0, 0), 1'b1, 1'b1, fa, fd);
        applyStimulus(1'b1, g, 1'b0, idleD, 1'b1, 1'b1, fa, fd);
        drain();

        // Reset in the middle of an 8-beat Put.
        for (int b = 0; b < 3; b++) sendA(mkA(PutFullData, 6, 'h70));
        host_a = mkA(PutFullData, 6, 'h70);
        doReset(1);
        idleCycles(1);
        for (int b = 0; b < 8; b++) sendA(mkA(PutFullData, 6, 'h71));
        drain();

        // Random traffic with held payloads and random backpressure.
        aPend = 1'b0;
        dPend = 1'b0;
        ra    = idleA;
        rd    = idleD;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            noNew = (cyc >= 2500);
            if (!aPend) begin
                if (aLeft > 0) begin
                    if ($urandom_range(0, 9) < 7) begin
                        ra    = mkA(ra.opcode, int'(ra.size), int'(ra.source));
                        aPend = 1'b1;
                    end
                end else if (!noNew && $urandom_range(0, 9) < 6) begin
                    ra    = mkA($urandom_range(0, 1) ? Get : PutFullData,
                                int'($urandom_range(0, 6)), int'($urandom_range(0, 255)));
                    aPend = 1'b1;
                end
            end
            if (!dPend) begin
                if (dLeft > 0) begin
                    rd    = mkD(rd.opcode, int'(rd.size), int'(rd.source));
                    dPend = 1'b1;
                end else if ($urandom_range(0, 9) < 4) begin
                    pick = int'($urandom_range(0, NumSlots - 1));
                    for (int k = 0; k < NumSlots; k++) begin
                        int s;
                        s = (pick + k) % NumSlots;
                        if (!dPend && busy[s] && !(aLeft > 0 && aSlot == s)) begin
                            rd    = mkD(slotIsGet[s] ? AccessAckData : AccessAck, slotSize[s], s);
                            dPend = 1'b1;
                        end
                    end
                end
            end
            applyStimulus(aPend, ra, dPend, rd, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0, fa, fd);
            if (fa) aPend = 1'b0;
            if (fd) dPend = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
